// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA/SVGA raster timing generator.
// Free-running horizontal/vertical counters advanced by a pixel-rate enable,
// decoded into coordinates, data enable, polarity-applied syncs and
// line/frame start strobes.
// Optional macro VGA_TIMING_OUTREG_EN: adds one output register stage on all
// outputs, updated every clk. Without it the outputs are zero-latency decodes.
module vga_timing_gen #(
    parameter int   H_ACTIVE  = 800,
    parameter int   H_FP      = 40,
    parameter int   H_SYNC    = 128,
    parameter int   H_BP      = 88,
    parameter int   V_ACTIVE  = 600,
    parameter int   V_FP      = 1,
    parameter int   V_SYNC    = 4,
    parameter int   V_BP      = 23,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1,
    parameter int   CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All decode thresholds are held as CNT_W-bit constants so every compare
    // is an unsigned CNT_W-bit compare against the counters.
    localparam logic [CNT_W-1:0] ZERO_C       = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST_C     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACTIVE_C   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACTIVE_C   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Elaboration-time legality of the timing parameters.
    if (H_TOTAL > (2 ** CNT_W)) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL > (2 ** CNT_W)) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
    if ((H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1)) begin : g_h_param_chk
        $error("vga_timing_gen: every horizontal timing parameter must be >= 1");
    end
    if ((V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_v_param_chk
        $error("vga_timing_gen: every vertical timing parameter must be >= 1");
    end

    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic             de_s;
    logic             hsync_s;
    logic             vsync_s;
    logic             line_start_s;
    logic             frame_start_s;

    // Raster counters: h wraps at end of line, v steps on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_r <= ZERO_C;
            v_cnt_r <= ZERO_C;
        end else if (pix_en) begin
            if (h_cnt_r == H_LAST_C) begin
                h_cnt_r <= ZERO_C;
                if (v_cnt_r == V_LAST_C) begin
                    v_cnt_r <= ZERO_C;
                end else begin
                    v_cnt_r <= v_cnt_r + ONE_C;
                end
            end else begin
                h_cnt_r <= h_cnt_r + ONE_C;
            end
        end
    end

    // Decode visible region, sync pulses and start strobes from the counters.
    always_comb begin
        de_s          = 1'b0;
        hsync_s       = ~HSYNC_POL;
        vsync_s       = ~VSYNC_POL;
        line_start_s  = 1'b0;
        frame_start_s = 1'b0;

        if ((h_cnt_r < H_ACTIVE_C) && (v_cnt_r < V_ACTIVE_C)) begin
            de_s = 1'b1;
        end else begin
            de_s = 1'b0;
        end

        if ((h_cnt_r >= H_SYNC_BEG_C) && (h_cnt_r < H_SYNC_END_C)) begin
            hsync_s = HSYNC_POL;
        end else begin
            hsync_s = ~HSYNC_POL;
        end

        if ((v_cnt_r >= V_SYNC_BEG_C) && (v_cnt_r < V_SYNC_END_C)) begin
            vsync_s = VSYNC_POL;
        end else begin
            vsync_s = ~VSYNC_POL;
        end

        // Strobes are suppressed while reset is held so the first enabled
        // cycle after release is the one that marks the new frame.
        if (pix_en && !rst && (h_cnt_r == ZERO_C)) begin
            line_start_s  = 1'b1;
            frame_start_s = (v_cnt_r == ZERO_C);
        end else begin
            line_start_s  = 1'b0;
            frame_start_s = 1'b0;
        end
    end

`ifdef VGA_TIMING_OUTREG_EN
    logic [CNT_W-1:0] x_r;
    logic [CNT_W-1:0] y_r;
    logic             de_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             line_start_r;
    logic             frame_start_r;

    // Output stage: one-clk delayed copy of the decode, refreshed every clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r           <= ZERO_C;
            y_r           <= ZERO_C;
            de_r          <= 1'b0;
            hsync_r       <= ~HSYNC_POL;
            vsync_r       <= ~VSYNC_POL;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            x_r           <= h_cnt_r;
            y_r           <= v_cnt_r;
            de_r          <= de_s;
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            line_start_r  <= line_start_s;
            frame_start_r <= frame_start_s;
        end
    end

    assign x           = x_r;
    assign y           = y_r;
    assign de          = de_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
`else
    assign x           = h_cnt_r;
    assign y           = v_cnt_r;
    assign de          = de_s;
    assign hsync       = hsync_s;
    assign vsync       = vsync_s;
    assign line_start  = line_start_s;
    assign frame_start = frame_start_s;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized bench for vga_timing_gen using a reduced
// raster. The reference model tracks only "enabled pixel ticks since reset"
// and derives every output from that count with division and modulo.
module tb_vga_timing_gen;

    localparam int   H_ACTIVE  = 8;
    localparam int   H_FP      = 2;
    localparam int   H_SYNC    = 3;
    localparam int   H_BP      = 2;
    localparam int   V_ACTIVE  = 5;
    localparam int   V_FP      = 1;
    localparam int   V_SYNC    = 2;
    localparam int   V_BP      = 1;
    localparam logic HSYNC_POL = 1'b0;
    localparam logic VSYNC_POL = 1'b1;
    localparam int   CNT_W     = 4;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

`ifdef VGA_TIMING_OUTREG_EN
    localparam bit OUTREG = 1'b1;
`else
    localparam bit OUTREG = 1'b0;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
        logic             de;
        logic             hs;
        logic             vs;
        logic             ls;
        logic             fs;
    } out_t;

    localparam out_t RST_REG = '{x: '0, y: '0, de: 1'b0, hs: ~HSYNC_POL,
                                 vs: ~VSYNC_POL, ls: 1'b0, fs: 1'b0};

    logic             clk;
    logic             rst;
    logic             pix_en;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             de;
    logic             hsync;
    logic             vsync;
    logic             line_start;
    logic             frame_start;

    int   n_checks;
    int   n_fail;
    int   pos;
    out_t exp_reg;
    int   cyc;
    int   st_fs, st_ls, st_de, st_hs, st_vs;
    int   fs_first, fs_second;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_en(pix_en),
        .x(x),
        .y(y),
        .de(de),
        .hsync(hsync),
        .vsync(vsync),
        .line_start(line_start),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected combinational outputs for a tick count, enable and reset level.
    function automatic out_t model_out(input int p, input logic pen, input logic r);
        out_t o;
        int   hx;
        int   vy;
        hx   = p % H_TOTAL;
        vy   = (p / H_TOTAL) % V_TOTAL;
        o.x  = CNT_W'(hx);
        o.y  = CNT_W'(vy);
        o.de = (hx < H_ACTIVE) && (vy < V_ACTIVE);
        o.hs = ((hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC)) ? HSYNC_POL : ~HSYNC_POL;
        o.vs = ((vy >= V_ACTIVE + V_FP) && (vy < V_ACTIVE + V_FP + V_SYNC)) ? VSYNC_POL : ~VSYNC_POL;
        o.ls = pen && !r && (hx == 0);
        o.fs = o.ls && (vy == 0);
        return o;
    endfunction

    task automatic clear_stats();
        st_fs = 0; st_ls = 0; st_de = 0; st_hs = 0; st_vs = 0;
        fs_first = -1; fs_second = -1;
    endtask

    // One clk cycle: model edge update, drive inputs between edges, compare.
    task automatic run_cycle(input logic pen_nx, input logic rst_nx);
        out_t e;
        @(posedge clk);
        if (rst) begin
            exp_reg = RST_REG;
        end else begin
            exp_reg = model_out(pos, pix_en, 1'b0);
            if (pix_en) pos = (pos + 1) % FRAME;
        end
        #2;
        pix_en = pen_nx;
        rst    = rst_nx;
        if (rst_nx) begin
            pos     = 0;
            exp_reg = RST_REG;
        end
        #2;
        e = OUTREG ? exp_reg : model_out(pos, pix_en, rst);
        check("x", 32'(x), 32'(e.x));
        check("y", 32'(y), 32'(e.y));
        check("de", 32'(de), 32'(e.de));
        check("hsync", 32'(hsync), 32'(e.hs));
        check("vsync", 32'(vsync), 32'(e.vs));
        check("line_start", 32'(line_start), 32'(e.ls));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        if (frame_start) begin
            st_fs++;
            if (fs_first < 0) fs_first = cyc;
            else if (fs_second < 0) fs_second = cyc;
        end
        if (line_start) st_ls++;
        if (de) st_de++;
        if (hsync == HSYNC_POL) st_hs++;
        if (vsync == VSYNC_POL) st_vs++;
        cyc++;
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        pix_en   = 1'b0;
        pos      = 0;
        exp_reg  = RST_REG;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        clear_stats();

        // Reset held: reset-state decode, with and without enable.
        run_cycle(1'b0, 1'b1);
        run_cycle(1'b1, 1'b1);
        run_cycle(1'b1, 1'b1);

        // One full frame with the enable held high: totals per frame.
        clear_stats();
        for (int i = 0; i < FRAME; i++) run_cycle(1'b1, 1'b0);
        check("frame_fs_count", 32'(st_fs), 32'd1);
        check("frame_ls_count", 32'(st_ls), 32'(V_TOTAL));
        check("frame_de_count", 32'(st_de), 32'(H_ACTIVE * V_ACTIVE));
        check("frame_hs_count", 32'(st_hs), 32'(H_SYNC * V_TOTAL));
        check("frame_vs_count", 32'(st_vs), 32'(V_SYNC * H_TOTAL));

        // Random enable with occasional mid-frame reset pulses.
        for (int i = 0; i < 2000; i++) begin
            run_cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 149) == 0));
        end
        run_cycle(1'b1, 1'b0);

        // Enable toggled every cycle: frame period doubles.
        run_cycle(1'b0, 1'b1);
        clear_stats();
        for (int i = 0; i < 2 * FRAME + 2; i++) run_cycle(logic'((i % 2) == 0), 1'b0);
        check("toggle_fs_count", 32'(st_fs), 32'd2);
        check("toggle_frame_period", 32'(fs_second - fs_first), 32'(2 * FRAME));
        check("toggle_ls_count", 32'(st_ls), 32'(V_TOTAL + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 40, horizontal front-porch pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 128, horizontal sync-pulse pixels.
REQ-004 The block SHALL have parameter H_BP, default 88, horizontal back-porch pixels.
REQ-005 The block SHALL have parameters V_ACTIVE 600, V_FP 1, V_SYNC 4 and V_BP 23, which are the vertical equivalents in lines.
REQ-006 The block SHALL have parameter HSYNC_POL, default 1, the asserted level of hsync; VSYNC_POL, default 1, is the asserted level of vsync.
REQ-007 The block SHALL have parameter CNT_W, default 11, the counter and coordinate width.
REQ-008 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-009 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-010 The block SHALL have port pix_en, input, 1 bit, a pixel-rate clock enable; the counters advance only when it is high.
REQ-011 The block SHALL have port x, output, CNT_W bits, the horizontal position (h_cnt).
REQ-012 The block SHALL have port y, output, CNT_W bits, the vertical position (v_cnt).
REQ-013 The block SHALL have port de, output, 1 bit, data enable (visible region).
REQ-014 The block SHALL have ports hsync and vsync, outputs, 1 bit each, the polarity-applied sync signals.
REQ-015 The block SHALL have ports line_start and frame_start, outputs, 1 bit each, single-cycle strobes.

Function
REQ-016 The block SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; the defaults give 1056 and 628.
REQ-017 h_cnt SHALL increment on each clk edge with pix_en=1, wrapping from H_TOTAL-1 to 0; it SHALL hold when pix_en=0.
REQ-018 v_cnt SHALL increment only on an edge where pix_en=1 and h_cnt=H_TOTAL-1, wrapping from V_TOTAL-1 to 0 on that same edge.
REQ-019 The simultaneous h and v wrap at (H_TOTAL-1, V_TOTAL-1) SHALL produce (0,0) on the next edge, with no skipped or repeated line.
REQ-020 de SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-021 hsync SHALL equal HSYNC_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, and ~HSYNC_POL otherwise.
REQ-022 vsync SHALL equal VSYNC_POL iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, and SHALL change only at the line boundary.
REQ-023 line_start SHALL be 1 iff pix_en=1 and h_cnt=0; frame_start SHALL be 1 iff pix_en=1, h_cnt=0 and v_cnt=0.
REQ-024 While pix_en is held low, all outputs SHALL remain static except the strobes, which SHALL be 0.
REQ-025 All comparisons SHALL be unsigned CNT_W-bit; H_TOTAL and V_TOTAL SHALL each be <= 2**CNT_W, and each timing parameter SHALL be >=1, both enforced by elaboration-time checks.

Reset
REQ-026 Asserting rst SHALL asynchronously set h_cnt=0 and v_cnt=0, regardless of clk or pix_en.
REQ-027 During reset, decoded outputs SHALL be: x=0, y=0, de=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=0, frame_start=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; the first pix_en cycle after release SHALL assert line_start=1 and frame_start=1.

Configuration
REQ-029 Macro VGA_TIMING_OUTREG_EN, when defined, SHALL place one output register stage on x, y, de, hsync, vsync, line_start and frame_start.
REQ-030 With VGA_TIMING_OUTREG_EN defined, each output SHALL equal its undefined-macro value from the previous clk edge; the registers update every clk regardless of pix_en.
REQ-031 With VGA_TIMING_OUTREG_EN defined, the output registers SHALL reset to x=0, y=0, de=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, and strobes 0.
REQ-032 Without VGA_TIMING_OUTREG_EN, outputs SHALL be combinational decodes of the counters, with zero latency.

Verification
REQ-033 Defaults, pix_en=1 for 1056*628 cycles -> exactly one frame_start, 628 line_start, and 800*600=480000 de cycles.
REQ-034 Defaults -> hsync=1 exactly for h_cnt 840..967 (128 cycles/line); vsync=1 exactly for lines 601..604.
REQ-035 pix_en toggled 1/0 every cycle -> the frame takes 2*1056*628 clk cycles, the strobes never last more than 1 cycle, and x holds on pix_en=0 cycles.
REQ-036 Wrap at x=1055, y=627 with pix_en=1 -> next edge gives x=0, y=0, frame_start=1.
REQ-037 rst pulsed at x=500, y=300 between clk edges -> x=y=0 immediately; the first pix_en cycle after release gives frame_start=1.
REQ-038 HSYNC_POL=0, H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48 -> hsync=0 for h_cnt 656..751, 800-cycle line; with VGA_TIMING_OUTREG_EN every output is delayed exactly 1 clk.
